// File: rtl/blft_pkg.sv
// Shared state encoding and default geometry for the bilateral-filter frame host.
package blft_pkg;

    localparam int BLFT_AW      = 16;
    localparam int BLFT_DW      = 8;
    localparam int BLFT_TIMEOUT = 200000;
    localparam int BLFT_TW      = 18;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DUMP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/blft_frame_ram.sv
// 2**AW x DW frame store: one write port, one registered read port (1 cycle).
// The read register only updates on re, so it holds its value while a consumer stalls.
module blft_frame_ram
    import blft_pkg::*;
#(
    parameter int AW = BLFT_AW,
    parameter int DW = BLFT_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/blft_frame_host.sv
// Frame host for the bilateral filter: load frame, run filter against src/dst RAMs, dump result.
// Reads answer in 1 cycle; dump output is a registered stream that holds under m_ready backpressure.
module blft_frame_host
    import blft_pkg::*;
#(
    parameter int AW      = BLFT_AW,
    parameter int DW      = BLFT_DW,
    parameter int TIMEOUT = BLFT_TIMEOUT,
    parameter int TW      = BLFT_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          flt_rst,
    input  logic [AW-1:0] flt_in_addr,
    output logic          flt_in_valid,
    output logic [DW-1:0] flt_in_data,
    input  logic          flt_out_valid,
    input  logic [AW-1:0] flt_out_addr,
    input  logic [DW-1:0] flt_out_data,
    input  logic          flt_finish,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic          done,
    output logic          err_timeout,
    output logic [AW:0]   wr_count
);

    localparam logic [AW:0] WR_MAX = {1'b1, {AW{1'b0}}};

    state_t        state;
    logic [AW-1:0] ld_cnt;
    logic [AW-1:0] dump_addr;
    logic          dump_issued;
    logic [TW-1:0] cyc;

    logic ld_fire;
    logic run;
    logic m_fire;
    logic dump_rd;
    logic run_end;

    assign ld_fire = (state == ST_LOAD) && s_valid && s_ready;
    assign run     = (state == ST_RUN);
    assign m_fire  = m_valid && m_ready;
    assign run_end = flt_finish || (cyc == TW'(TIMEOUT - 1));
    // Fetch the next result word whenever the output register is empty or draining.
    assign dump_rd = (state == ST_DUMP) && !dump_issued && (!m_valid || m_fire);

    blft_frame_ram #(.AW(AW), .DW(DW)) u_src_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ld_fire),
        .waddr (ld_cnt),
        .wdata (s_data),
        .re    (run),
        .raddr (flt_in_addr),
        .rdata (flt_in_data)
    );

    blft_frame_ram #(.AW(AW), .DW(DW)) u_dst_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (run && flt_out_valid),
        .waddr (flt_out_addr),
        .wdata (flt_out_data),
        .re    (dump_rd),
        .raddr (dump_addr),
        .rdata (m_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            flt_rst      <= 1'b1;
            s_ready      <= 1'b0;
            flt_in_valid <= 1'b0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            wr_count     <= '0;
            ld_cnt       <= '0;
            dump_addr    <= '0;
            dump_issued  <= 1'b0;
            cyc          <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_LOAD;
                        s_ready     <= 1'b1;
                        done        <= 1'b0;
                        err_timeout <= 1'b0;
                        wr_count    <= '0;
                        ld_cnt      <= '0;
                    end
                end
                ST_LOAD: begin
                    if (ld_fire) begin
                        ld_cnt <= ld_cnt + 1'b1;
                        if (ld_cnt == '1) begin
                            state   <= ST_RUN;
                            s_ready <= 1'b0;
                            flt_rst <= 1'b0;
                            cyc     <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (flt_out_valid && (wr_count != WR_MAX)) begin
                        wr_count <= wr_count + 1'b1;
                    end
                    if (run_end) begin
                        state        <= ST_DUMP;
                        flt_rst      <= 1'b1;
                        flt_in_valid <= 1'b0;
                        dump_addr    <= '0;
                        dump_issued  <= 1'b0;
                        if (!flt_finish) begin
                            err_timeout <= 1'b1;
                        end
                    end else begin
                        flt_in_valid <= 1'b1;
                        cyc          <= cyc + 1'b1;
                    end
                end
                ST_DUMP: begin
                    if (dump_rd) begin
                        m_valid   <= 1'b1;
                        m_last    <= (dump_addr == '1);
                        dump_addr <= dump_addr + 1'b1;
                        if (dump_addr == '1) begin
                            dump_issued <= 1'b1;
                        end
                    end else if (m_fire) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                    end
                    if (m_fire && m_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blft_frame_host.sv
// Scoreboard bench for blft_frame_host at AW=4: load, filter reads/writes, timeout, dump backpressure, reset abort.
module tb_blft_frame_host;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NPIX = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          flt_rst;
    logic [AW-1:0] flt_in_addr;
    logic          flt_in_valid;
    logic [DW-1:0] flt_in_data;
    logic          flt_out_valid;
    logic [AW-1:0] flt_out_addr;
    logic [DW-1:0] flt_out_data;
    logic          flt_finish;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          done;
    logic          err_timeout;
    logic [AW:0]   wr_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] src_m [NPIX];
    logic [DW-1:0] dst_m [NPIX];
    logic [DW-1:0] rdq [$];
    logic [DW-1:0] dq [$];

    blft_frame_host #(.AW(AW), .DW(DW), .TIMEOUT(64), .TW(7)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .flt_rst       (flt_rst),
        .flt_in_addr   (flt_in_addr),
        .flt_in_valid  (flt_in_valid),
        .flt_in_data   (flt_in_data),
        .flt_out_valid (flt_out_valid),
        .flt_out_addr  (flt_out_addr),
        .flt_out_data  (flt_out_data),
        .flt_finish    (flt_finish),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .done          (done),
        .err_timeout   (err_timeout),
        .wr_count      (wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_frame(input logic [7:0] seed);
        int  n;
        int  g;
        logic was;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ld_s_ready", 32'(s_ready), 32'd1);
        chk("ld_err_clr", 32'(err_timeout), 32'd0);
        chk("ld_done_clr", 32'(done), 32'd0);
        chk("ld_wr_clr", 32'(wr_count), 32'd0);
        n = 0;
        g = 0;
        s_valid = 1'b1;
        while (n < NPIX && g < 100) begin
            s_data = seed + 8'(n);
            was = s_ready;
            if (was && n == NPIX - 1) chk("ld_flt_rst_hi", 32'(flt_rst), 32'd1);
            tick();
            g++;
            if (was) begin
                src_m[n] = seed + 8'(n);
                n++;
            end
        end
        s_valid = 1'b0;
        chk("ld_accepts", 32'(n), 32'(NPIX));
        chk("ld_s_ready_drop", 32'(s_ready), 32'd0);
        chk("ld_flt_rst_fall", 32'(flt_rst), 32'd0);
    endtask

    task automatic run_reads();
        logic [AW-1:0] addrs [4];
        logic [DW-1:0] e;
        addrs[0] = 4'd5; addrs[1] = 4'd15; addrs[2] = 4'd0; addrs[3] = 4'd9;
        for (int i = 0; i < 4; i++) begin
            flt_in_addr = addrs[i];
            rdq.push_back(src_m[addrs[i]]);
            tick();
            chk("rd_valid", 32'(flt_in_valid), 32'd1);
            e = rdq.pop_front();
            chk("rd_data", 32'(flt_in_data), 32'(e));
        end
    endtask

    task automatic run_writes(input int nwr, input logic [7:0] base, input bit fin);
        for (int a = 0; a < nwr; a++) begin
            flt_out_valid = 1'b1;
            flt_out_addr  = AW'(a);
            flt_out_data  = base - 8'(a);
            dst_m[a]      = base - 8'(a);
            flt_finish    = fin && (a == nwr - 1);
            tick();
        end
        flt_out_valid = 1'b0;
        flt_finish    = 1'b0;
    endtask

    task automatic dump(input int stop_at, input bit toggle);
        logic [3:0]    pat;
        logic          held;
        logic [DW-1:0] hd;
        logic          hl;
        logic [DW-1:0] e;
        int            beats;
        int            g;
        pat = 4'b1001;
        held = 1'b0;
        hd = '0;
        hl = 1'b0;
        beats = 0;
        g = 0;
        for (int a = 0; a < NPIX; a++) dq.push_back(dst_m[a]);
        chk("dump_entry_mvalid", 32'(m_valid), 32'd0);
        while (!done && g < 200) begin
            if (stop_at >= 0 && beats == stop_at) break;
            m_ready = toggle ? pat[g % 4] : 1'b1;
            if (g == 1) chk("dump_first_mvalid", 32'(m_valid), 32'd1);
            if (m_valid) begin
                if (held) begin
                    chk("dump_hold_dat", 32'(m_data), 32'(hd));
                    chk("dump_hold_last", 32'(m_last), 32'(hl));
                end
                if (m_ready) begin
                    if (dq.size() == 0) begin
                        chk("dump_extra_beat", 32'd1, 32'd0);
                    end else begin
                        e = dq.pop_front();
                        chk("dump_dat", 32'(m_data), 32'(e));
                        chk("dump_last", 32'(m_last), 32'(beats == NPIX - 1));
                    end
                    beats++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd = m_data;
                    hl = m_last;
                end
            end
            tick();
            g++;
        end
        m_ready = 1'b0;
        if (stop_at < 0) begin
            chk("dump_beats", 32'(beats), 32'(NPIX));
            chk("dump_done", 32'(done), 32'd1);
            chk("dump_mvalid_off", 32'(m_valid), 32'd0);
            chk("dump_queue_empty", 32'(dq.size()), 32'd0);
        end
    endtask

    initial begin
        int cnt;
        int g;
        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        flt_in_addr = '0;
        flt_out_valid = 1'b0;
        flt_out_addr = '0;
        flt_out_data = '0;
        flt_finish = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        chk("rst_flt_rst", 32'(flt_rst), 32'd1);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_in_valid", 32'(flt_in_valid), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_in_data", 32'(flt_in_data), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        rst = 1'b0;
        tick();

        // Frame 1: full write-back, finish on the last write, stalled dump.
        load_frame(8'h00);
        run_reads();
        run_writes(NPIX, 8'hFF, 1'b1);
        chk("f1_flt_rst_back", 32'(flt_rst), 32'd1);
        chk("f1_in_valid_off", 32'(flt_in_valid), 32'd0);
        chk("f1_wr_count", 32'(wr_count), 32'd16);
        chk("f1_no_timeout", 32'(err_timeout), 32'd0);
        dump(-1, 1'b1);

        // Frame 2: partial write-back, no finish, timeout after 64 RUN cycles.
        load_frame(8'hA0);
        cnt = 0;
        for (int a = 0; a < 4; a++) begin
            if (flt_rst == 1'b0) cnt++;
            flt_out_valid = 1'b1;
            flt_out_addr  = AW'(a);
            flt_out_data  = 8'h3F - 8'(a);
            dst_m[a]      = 8'h3F - 8'(a);
            tick();
        end
        flt_out_valid = 1'b0;
        chk("f2_no_err_early", 32'(err_timeout), 32'd0);
        g = 0;
        while (flt_rst == 1'b0 && g < 200) begin
            cnt++;
            tick();
            g++;
        end
        chk("f2_run_cycles", 32'(cnt), 32'd64);
        chk("f2_err_timeout", 32'(err_timeout), 32'd1);
        chk("f2_wr_count", 32'(wr_count), 32'd4);
        flt_out_valid = 1'b1;
        flt_out_addr  = 4'd4;
        flt_out_data  = 8'hEE;
        dump(-1, 1'b0);
        flt_out_valid = 1'b0;
        chk("f2_wr_ignored", 32'(wr_count), 32'd4);
        chk("f2_err_sticky", 32'(err_timeout), 32'd1);

        // Frame 3: reset in the middle of the dump.
        load_frame(8'h30);
        run_reads();
        run_writes(NPIX, 8'h80, 1'b1);
        dump(7, 1'b0);
        rst = 1'b1;
        tick();
        chk("f3_rst_m_valid", 32'(m_valid), 32'd0);
        chk("f3_rst_flt_rst", 32'(flt_rst), 32'd1);
        chk("f3_rst_done", 32'(done), 32'd0);
        chk("f3_rst_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        dq.delete();
        tick();
        chk("f3_idle_m_valid", 32'(m_valid), 32'd0);

        // Frame 4: recovery after the abort.
        load_frame(8'h55);
        run_reads();
        run_writes(NPIX, 8'hC3, 1'b1);
        chk("f4_wr_count", 32'(wr_count), 32'd16);
        dump(-1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/blft_frame_host.md
Name: blft_frame_host

Overview:
- Frame-side counterpart of the bilateral filter: owns the source and result frame memories and acts as the memory responder the filter talks to.
- Loads a raster-order frame from an upstream stream, holds the filter in reset until the frame is complete, then releases it.
- Answers filter read addresses with pixel data and captures filter write-backs.
- On filter `finish`, streams the result frame downstream.

Parameters:
- AW, 16, pixel address width; frame = 2**AW pixels, address = {row, col}
- DW, 8, pixel data width
- TIMEOUT, 200000, maximum RUN cycles before abort
- TW, 18, width of the RUN cycle counter; must be ≥ clog2(TIMEOUT+1)

Ports:
- clk input 1 system clock
- rst input 1 synchronous active-high reset
- start input 1 begin a frame; sampled in IDLE/DONE only
- s_valid input 1 upstream pixel valid
- s_data input DW upstream pixel, raster order
- s_ready output 1 host accepts pixel (LOAD only)
- flt_rst output 1 reset driven to filter; high except in RUN
- flt_in_addr input AW filter read address
- flt_in_valid output 1 flt_in_data valid
- flt_in_data output DW source pixel for the address sampled one cycle earlier
- flt_out_valid input 1 filter write strobe
- flt_out_addr input AW filter write address
- flt_out_data input DW filter write pixel
- flt_finish input 1 filter done level
- m_valid output 1 result pixel valid
- m_data output DW result pixel, raster order
- m_last output 1 final result pixel
- m_ready input 1 downstream accept
- done output 1 frame complete; level, held in DONE
- err_timeout output 1 RUN aborted by timeout; sticky until next start
- wr_count output AW+1 filter writes accepted this frame

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - state=IDLE.
  - flt_rst=1.
  - s_ready, flt_in_valid, m_valid, m_last, done, err_timeout = 0.
  - flt_in_data, m_data, wr_count = 0.
  - Memory contents are not cleared.
  - Reset mid-operation aborts immediately, with no partial dump.
- States: IDLE, LOAD, RUN, DUMP, DONE.
- IDLE:
  - start=1 → LOAD; clear load counter, wr_count, err_timeout.
- LOAD:
  - s_ready=1.
  - On s_valid&s_ready: src_mem[ld_cnt] ← s_data; ld_cnt++.
  - After the accept at ld_cnt = 2**AW−1 → RUN.
- RUN:
  - flt_rst deasserts (registered) on the first RUN cycle.
  - Every cycle: flt_in_data ← src_mem[flt_in_addr] and flt_in_valid ← 1.
  - Read latency is exactly 1 cycle; address space wraps modulo 2**AW.
  - flt_out_valid=1: dst_mem[flt_out_addr] ← flt_out_data; wr_count++ (saturates at 2**AW).
  - Repeated writes to the same address: last write wins.
  - Cycle counter runs from 0.
  - flt_finish=1 → DUMP. A write in the same cycle as flt_finish is still accepted.
  - Counter reaches TIMEOUT with no finish → err_timeout=1, go to DUMP (partial result is dumped).
- Leaving RUN:
  - flt_rst=1 and flt_in_valid=0 from the next cycle.
  - Writes outside RUN are ignored.
- DUMP:
  - Registered read of dst_mem in raster order; first m_valid 1 cycle after DUMP entry.
  - m_data, m_last hold while m_valid&!m_ready.
  - Each handshake advances the address.
  - m_last=1 with address 2**AW−1.
  - Handshake on m_last → DONE.
- DONE:
  - done=1.
  - start=1 → LOAD: done→0, counters cleared.
- start in LOAD/RUN/DUMP is ignored.

Decomposition:
- Package blft_pkg:
  - state encoding constants (IDLE=0, LOAD=1, RUN=2, DUMP=3, DONE=4)
  - AW/DW defaults
  - TIMEOUT default
- Sub-module blft_frame_ram:
  - single-clock, 1 write port, 1 registered read port, 2**AW×DW
  - instantiated twice: src and dst
- Control FSM, counters, and output registers stay in the top.

Test Plan:
- AW=4, DW=8, TIMEOUT=64; load pixels 0..15 with s_valid=1 continuously → s_ready drops after 16 accepts; flt_rst falls exactly 1 cycle after the 16th accept.
- RUN, flt_in_addr=5 at cycle t → flt_in_data=5 with flt_in_valid=1 at t+1; addr sweep 15,0 → data 15,0.
- Filter model writes out_data = 255−addr for all 16 addresses, then flt_finish, with the last write coincident with finish → wr_count=16; dump m_data=255..240; m_last only on the 16th beat; done=1 after it.
- Downstream m_ready toggling 1,0,0,1 during dump → m_data/m_last stable while stalled; no beat lost or duplicated.
- No finish from the filter → err_timeout=1 after 64 RUN cycles; unwritten addresses dump stale contents; done=1; next start clears err_timeout.
- rst=1 mid-DUMP at beat 7 → next cycle m_valid=0, flt_rst=1, state IDLE; new start reloads and completes normally.
